updown_sweep_ctrl: RTL and testbench
====================================

Name: updown_sweep_ctrl

Overview:
Sweep sequencer for the 4-bit saturating up/down counter (en/up inputs; count and min_max outputs). On a start command it moves the counter to a programmed low limit. It then ping-pongs the counter between the low and high limits at a programmed step rate, dwelling at each endpoint. It runs for a programmed number of passes or continuously, and reports done, error and abort. It sits between the register/config layer and the counter instance.

Parameters:
WIDTH, 4, counter width; must match the counter.
DIV_W, 8, step-rate prescaler width.
DWELL_W, 8, endpoint dwell counter width.
PASS_W, 4, pass counter width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle command; ignored while busy
abort  in  1  single-cycle command; stops the sweep
cfg_lo  in  WIDTH  low limit, captured on start
cfg_hi  in  WIDTH  high limit, captured on start
cfg_div  in  DIV_W  step every cfg_div+1 cycles, captured on start
cfg_dwell  in  DWELL_W  endpoint dwell cycles, captured on start
cfg_passes  in  PASS_W  number of up/down passes; 0 = continuous
cnt_value  in  WIDTH  counter count output
cnt_min_max  in  1  counter saturation flag
cnt_en  out  1  counter enable (combinational)
cnt_up  out  1  counter direction (combinational)
busy  out  1  high in any state other than IDLE
phase  out  3  current state encoding
pass_count  out  PASS_W  completed passes
done  out  1  1-cycle pulse
err  out  1  1-cycle pulse
aborted  out  1  1-cycle pulse

Behaviour:
- Reset: state IDLE. pass_count, internal counters and captured config 0. done/err/aborted 0. cnt_en 0.
- Counter timing: the counter updates on the edge where cnt_en=1, so cnt_value shows the new value the next cycle. cnt_en is combinational from state, tick and cnt_value, which guarantees no overshoot.
- tick: prescaler div_cnt clears on entry to SEEK/UP/DOWN. Each cycle in a moving state: if div_cnt==cfg_div then tick=1 and div_cnt<=0, else div_cnt++. cfg_div=0 gives a step every cycle.
- cnt_en = (state in SEEK/UP/DOWN) & tick & (cnt_value != target).
  - Target is lo in SEEK/DOWN and hi in UP.
  - cnt_up = 1 in UP; 0 in DOWN; (cnt_value<lo) in SEEK; 0 elsewhere.
- States (phase encoding): IDLE=0, SEEK=1, UP=2, DWELL_HI=3, DOWN=4, DWELL_LO=5.
- IDLE:
  - On start with cfg_lo>cfg_hi: err pulse next cycle; stay IDLE; nothing captured.
  - Otherwise capture config, clear pass_count, go to SEEK.
- SEEK: when cnt_value==lo, go to UP. This includes the case where the counter is already at lo.
- UP: when cnt_value==hi, go to DWELL_HI. If lo==hi, UP exits on its first cycle.
- DWELL_HI / DWELL_LO:
  - Dwell counter clears on entry; stay max(1, cfg_dwell) cycles.
  - Then DWELL_HI goes to DOWN and DWELL_LO goes to UP.
- DOWN: when cnt_value==lo:
  - pass_count++ (wraps at 2^PASS_W).
  - If cfg_passes!=0 and the new pass_count==cfg_passes: done pulse, go to IDLE.
  - Otherwise go to DWELL_LO.
- abort in any non-IDLE state:
  - Go to IDLE next edge; cnt_en is forced 0 in that same cycle.
  - aborted pulse.
  - pass_count holds.
  - abort has priority over every other transition. abort in IDLE is ignored.
- cnt_min_max=1 in any non-IDLE state: unexpected saturation. err pulse, go to IDLE; abort wins if both occur.
- start while busy: ignored. Captured config is unaffected by cfg_* changes mid-sweep.
- Pulses are registered and high for exactly one cycle, in the cycle after the causing event.

Decomposition:
- Shared package: state enum and phase encodings; limit-check function (lo<=hi).
- One natural sub-module: updown_sweep_tick, the prescaler (clear, div -> tick), reusable by other paced controllers.
- Dwell counter and FSM stay in the top module.

Test Plan:
1. Counter at 0, start with lo=3, hi=6, div=0, dwell=2, passes=1. Expected: count 0→3 (SEEK) → 6, 2 dwell cycles, → 3. Then done pulse, pass_count=1, busy drops.
2. div=3: consecutive count changes exactly 4 cycles apart. cnt_en high for 1 cycle per step.
3. lo=9, hi=4, start: err pulse next cycle, busy stays 0, cnt_en never asserted.
4. passes=0, lo=0, hi=15: runs continuously with pass_count incrementing. Abort mid-UP gives aborted pulse, IDLE next cycle and the count frozen. cnt_en is never high while count==0 in DOWN or count==15 in UP, so min_max is never raised.
5. Force cnt_min_max=1 during UP: err pulse, state IDLE. abort and min_max in the same cycle give aborted only.
6. Assert rst_n low mid-DOWN, asynchronously: all outputs 0 immediately and phase=0. A start after release sweeps normally.

Source files
------------

// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types and helpers for the up/down sweep sequencer.
`timescale 1ns/1ps
package updown_sweep_ctrl_pkg;

  // Sweep FSM states; the numeric values are visible on the phase output.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEEK     = 3'd1,
    ST_UP       = 3'd2,
    ST_DWELL_HI = 3'd3,
    ST_DOWN     = 3'd4,
    ST_DWELL_LO = 3'd5
  } sweep_state_e;

  // A sweep is only legal when the low limit does not exceed the high limit.
  function automatic logic limits_ok(input int unsigned lo, input int unsigned hi);
    return lo <= hi;
  endfunction

  // States in which the counter is being stepped and the prescaler runs.
  function automatic logic is_moving(input sweep_state_e s);
    return (s == ST_SEEK) || (s == ST_UP) || (s == ST_DOWN);
  endfunction

endpackage

// File: rtl/updown_sweep_tick.sv
// Step-rate prescaler: while run is high, tick fires once every div+1 cycles.
// clear restarts the count so the first tick after a clear lands div+1 cycles later.
`timescale 1ns/1ps
module updown_sweep_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  assign tick = run & (div_cnt == div);

  // Count up to div, wrap to zero on the tick; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for a saturating up/down counter: seek to the low limit,
// then ping-pong between limits with endpoint dwell, for N passes or forever.
// cnt_en is combinational and gated on cnt_value != target, so the counter
// never steps past a limit and never saturates in normal operation.
`timescale 1ns/1ps
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DIV_W   = 8,
  parameter int DWELL_W = 8,
  parameter int PASS_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cfg_lo,
  input  logic [WIDTH-1:0]   cfg_hi,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [PASS_W-1:0]  cfg_passes,
  input  logic [WIDTH-1:0]   cnt_value,
  input  logic               cnt_min_max,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               busy,
  output logic [2:0]         phase,
  output logic [PASS_W-1:0]  pass_count,
  output logic               done,
  output logic               err,
  output logic               aborted
);

  sweep_state_e       state_q, state_d;
  logic [WIDTH-1:0]   lo_q, hi_q, target;
  logic [DIV_W-1:0]   div_q;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt;
  logic [PASS_W-1:0]  passes_q, pass_next;
  logic               tick, cap, pass_inc, dwell_last;
  logic               done_d, err_d, abort_d;

  assign busy       = (state_q != ST_IDLE);
  assign phase      = state_q;
  assign pass_next  = pass_count + PASS_W'(1);
  // A programmed dwell of zero still spends one cycle at the endpoint.
  assign dwell_last = (dwell_q == '0) || (dwell_cnt == dwell_q - DWELL_W'(1));

  // Prescaler restarts on every state change so each moving state starts fresh.
  updown_sweep_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_d != state_q),
    .run   (is_moving(state_q)),
    .div   (div_q),
    .tick  (tick)
  );

  // Next state, counter controls and pulse requests; abort outranks saturation,
  // which outranks all normal transitions.
  always_comb begin
    state_d  = state_q;
    cap      = 1'b0;
    pass_inc = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    abort_d  = 1'b0;
    target   = hi_q;
    cnt_up   = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!limits_ok(32'(cfg_lo), 32'(cfg_hi))) begin
            err_d = 1'b1;
          end else begin
            cap     = 1'b1;
            state_d = ST_SEEK;
          end
        end
      end
      ST_SEEK: begin
        target = lo_q;
        cnt_up = (cnt_value < lo_q);
        if (cnt_value == lo_q) state_d = ST_UP;
      end
      ST_UP: begin
        target = hi_q;
        cnt_up = 1'b1;
        if (cnt_value == hi_q) state_d = ST_DWELL_HI;
      end
      ST_DWELL_HI: begin
        if (dwell_last) state_d = ST_DOWN;
      end
      ST_DOWN: begin
        target = lo_q;
        if (cnt_value == lo_q) begin
          pass_inc = 1'b1;
          if ((passes_q != '0) && (pass_next == passes_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DWELL_LO;
          end
        end
      end
      ST_DWELL_LO: begin
        if (dwell_last) state_d = ST_UP;
      end
      default: state_d = ST_IDLE;
    endcase

    if (is_moving(state_q)) cnt_en = tick & (cnt_value != target);

    if (state_q != ST_IDLE) begin
      if (abort) begin
        state_d  = ST_IDLE;
        abort_d  = 1'b1;
        done_d   = 1'b0;
        pass_inc = 1'b0;
        cnt_en   = 1'b0;
      end else if (cnt_min_max) begin
        state_d  = ST_IDLE;
        err_d    = 1'b1;
        done_d   = 1'b0;
        pass_inc = 1'b0;
      end
    end
  end

  // State register and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      err     <= err_d;
      aborted <= abort_d;
    end
  end

  // Configuration snapshot taken on an accepted start; held for the whole sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q     <= '0;
      hi_q     <= '0;
      div_q    <= '0;
      dwell_q  <= '0;
      passes_q <= '0;
    end else if (cap) begin
      lo_q     <= cfg_lo;
      hi_q     <= cfg_hi;
      div_q    <= cfg_div;
      dwell_q  <= cfg_dwell;
      passes_q <= cfg_passes;
    end
  end

  // Dwell cycle counter: runs while staying in a dwell state, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if ((state_d == state_q) &&
                 ((state_q == ST_DWELL_HI) || (state_q == ST_DWELL_LO))) begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end else begin
      dwell_cnt <= '0;
    end
  end

  // Completed-pass counter: cleared on start, bumped each time DOWN reaches lo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count <= '0;
    end else if (cap) begin
      pass_count <= '0;
    end else if (pass_inc) begin
      pass_count <= pass_next;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl driving a behavioural 4-bit saturating counter.
`timescale 1ns/1ps
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [3:0] cfg_lo, cfg_hi, cfg_passes;
  logic [7:0] cfg_div, cfg_dwell;
  logic       cnt_en, cnt_up, busy, done, err, aborted;
  logic [2:0] phase;
  logic [3:0] pass_count;
  logic       cnt_min_max;

  // counter model
  logic [3:0] count;
  logic       mm;
  logic       force_mm;

  // scoreboard
  logic [3:0] exp_q[$];
  logic [3:0] obs_val[0:511];
  int         obs_cyc[0:511];
  int         obs_n = 0;
  int         rd = 0;
  logic [3:0] prev_count = 4'd0;
  int         cyc = 0;
  int         en_cycles = 0;
  int         viol = 0;

  int tests = 0;
  int fails = 0;
  int dwell_hi_cyc;

  // clock
  always #5 clk = ~clk;

  assign cnt_min_max = mm | force_mm;

  updown_sweep_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_lo      (cfg_lo),
    .cfg_hi      (cfg_hi),
    .cfg_div     (cfg_div),
    .cfg_dwell   (cfg_dwell),
    .cfg_passes  (cfg_passes),
    .cnt_value   (count),
    .cnt_min_max (cnt_min_max),
    .cnt_en      (cnt_en),
    .cnt_up      (cnt_up),
    .busy        (busy),
    .phase       (phase),
    .pass_count  (pass_count),
    .done        (done),
    .err         (err),
    .aborted     (aborted)
  );

  // Saturating up/down counter; flags an attempted step past 0 or 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
      mm    <= 1'b0;
    end else begin
      mm <= 1'b0;
      if (cnt_en) begin
        if (cnt_up) begin
          if (count == 4'd15) mm <= 1'b1;
          else count <= count + 4'd1;
        end else begin
          if (count == 4'd0) mm <= 1'b1;
          else count <= count - 4'd1;
        end
      end
    end
  end

  // Monitor: records every count change with its cycle stamp, enables and overshoots.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cnt_en === 1'b1) en_cycles = en_cycles + 1;
    if (rst_n === 1'b1 && (mm || (cnt_en && ((phase == 3'd2 && count == 4'd15) ||
                                             (phase == 3'd4 && count == 4'd0)))))
      viol = viol + 1;
    if (count !== prev_count) begin
      if (obs_n < 512) begin
        obs_val[obs_n] = count;
        obs_cyc[obs_n] = cyc;
        obs_n = obs_n + 1;
      end
      prev_count = count;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int a, input int b);
    if (a <= b) for (int i = a; i <= b; i++) exp_q.push_back(4'(i));
    else        for (int i = a; i >= b; i--) exp_q.push_back(4'(i));
  endtask

  // Compare every recorded count change against the expected queue.
  task automatic drain_sb(input string tag);
    logic [31:0] e;
    while (rd < obs_n) begin
      e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
      check(tag, 32'(obs_val[rd]), e);
      rd++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic do_start(input logic [3:0] lo, input logic [3:0] hi, input logic [7:0] div,
                          input logic [7:0] dwell, input logic [3:0] passes);
    @(negedge clk);
    cfg_lo = lo; cfg_hi = hi; cfg_div = div; cfg_dwell = dwell; cfg_passes = passes;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    dwell_hi_cyc = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (phase == 3'd3) dwell_hi_cyc++;
      if (done === 1'b1) break;
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic wait_state(input logic [2:0] p, input int c, input int budget, input string tag);
    int n = 0;
    logic found;
    found = 1'b0;
    while (n < budget) begin
      if (phase == p && (c < 0 || count == c[3:0])) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    check(tag, 32'(found), 1);
  endtask

  initial begin
    int s, d1, d2, e0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; force_mm = 1'b0;
    cfg_lo = '0; cfg_hi = '0; cfg_div = '0; cfg_dwell = '0; cfg_passes = '0;
    repeat (3) @(negedge clk);
    check("rst_phase", 32'(phase), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt_en", 32'(cnt_en), 0);
    check("rst_pass", 32'(pass_count), 0);
    check("rst_pulses", {29'd0, done, err, aborted}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: seek 0->3, up to 6, dwell 2, down to 3, done
    push_range(1, 6); push_range(5, 3);
    do_start(4'd3, 4'd6, 8'd0, 8'd2, 4'd1);
    check("t1_busy", 32'(busy), 1);
    check("t1_phase_seek", 32'(phase), 1);
    wait_done(100, "t1_done");
    check("t1_dwell_hi", dwell_hi_cyc, 2);
    check("t1_pass", 32'(pass_count), 1);
    check("t1_busy_drop", 32'(busy), 0);
    @(negedge clk);
    check("t1_done_1cyc", 32'(done), 0);
    drain_sb("t1_sb");

    // 2: div=3, steps 4 cycles apart, one enable per step, dwell 0 acts as 1
    push_range(4, 5); push_range(4, 3);
    s = obs_n; e0 = en_cycles;
    do_start(4'd3, 4'd5, 8'd3, 8'd0, 4'd1);
    wait_done(100, "t2_done");
    check("t2_dwell_hi", dwell_hi_cyc, 1);
    check("t2_nchg", obs_n - s, 4);
    d1 = (obs_n - s >= 4) ? obs_cyc[s+1] - obs_cyc[s] : -1;
    d2 = (obs_n - s >= 4) ? obs_cyc[s+3] - obs_cyc[s+2] : -1;
    check("t2_gap_up", d1, 4);
    check("t2_gap_dn", d2, 4);
    check("t2_en_cycles", en_cycles - e0, 4);
    drain_sb("t2_sb");

    // 3: lo > hi rejected
    e0 = en_cycles;
    do_start(4'd9, 4'd4, 8'd0, 8'd1, 4'd1);
    check("t3_err", 32'(err), 1);
    check("t3_busy", 32'(busy), 0);
    @(negedge clk);
    check("t3_err_1cyc", 32'(err), 0);
    repeat (3) @(negedge clk);
    check("t3_phase", 32'(phase), 0);
    check("t3_no_en", en_cycles - e0, 0);

    // 4: continuous full-range sweep, abort mid-UP
    push_range(2, 0);
    push_range(1, 15); push_range(14, 0);
    push_range(1, 15); push_range(14, 0);
    push_range(1, 7);
    do_start(4'd0, 4'd15, 8'd0, 8'd1, 4'd0);
    wait_state(3'd5, -1, 200, "t4_lo1");
    check("t4_pass1", 32'(pass_count), 1);
    wait_state(3'd2, -1, 10, "t4_up2");
    wait_state(3'd5, -1, 200, "t4_lo2");
    check("t4_pass2", 32'(pass_count), 2);
    wait_state(3'd2, 7, 200, "t4_up7");
    abort = 1'b1;
    #1;
    check("t4_abort_en_gate", 32'(cnt_en), 0);
    @(negedge clk);
    abort = 1'b0;
    check("t4_aborted", 32'(aborted), 1);
    check("t4_phase", 32'(phase), 0);
    check("t4_frozen", 32'(count), 7);
    check("t4_pass_hold", 32'(pass_count), 2);
    check("t4_no_err", 32'(err), 0);
    @(negedge clk);
    check("t4_aborted_1cyc", 32'(aborted), 0);
    drain_sb("t4_sb");

    // 5a: saturation flag during UP
    exp_q.push_back(4'd8);
    do_start(4'd7, 4'd12, 8'd0, 8'd1, 4'd0);
    wait_state(3'd2, 8, 50, "t5_up8");
    exp_q.push_back(4'd9);
    force_mm = 1'b1;
    @(negedge clk);
    force_mm = 1'b0;
    check("t5_err", 32'(err), 1);
    check("t5_phase", 32'(phase), 0);
    check("t5_no_abort", 32'(aborted), 0);
    @(negedge clk);
    check("t5_err_1cyc", 32'(err), 0);
    // 5b: abort and saturation together
    exp_q.push_back(4'd10);
    do_start(4'd9, 4'd12, 8'd0, 8'd1, 4'd0);
    wait_state(3'd2, 10, 50, "t5_up10");
    force_mm = 1'b1; abort = 1'b1;
    @(negedge clk);
    force_mm = 1'b0; abort = 1'b0;
    check("t5b_aborted", 32'(aborted), 1);
    check("t5b_no_err", 32'(err), 0);
    check("t5b_phase", 32'(phase), 0);
    drain_sb("t5_sb");

    // 6: async reset mid-DOWN of the second pass, then a normal sweep
    push_range(9, 2); push_range(3, 12); push_range(11, 2);
    push_range(3, 12); push_range(11, 8);
    exp_q.push_back(4'd0);
    do_start(4'd2, 4'd12, 8'd0, 8'd1, 4'd3);
    wait_state(3'd5, -1, 200, "t6_lo1");
    wait_state(3'd4, 8, 200, "t6_dn8");
    check("t6_pass_pre", 32'(pass_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_phase", 32'(phase), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_cnt_ctl", {30'd0, cnt_en, cnt_up}, 0);
    check("t6_pass", 32'(pass_count), 0);
    check("t6_pulses", {29'd0, done, err, aborted}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_range(1, 3); push_range(2, 1); push_range(2, 3); push_range(2, 1);
    do_start(4'd1, 4'd3, 8'd1, 8'd0, 4'd2);
    check("t6_restart_busy", 32'(busy), 1);
    wait_done(300, "t6_done");
    check("t6_pass_done", 32'(pass_count), 2);
    check("t6_idle", 32'(phase), 0);
    drain_sb("t6_sb");

    check("no_overshoot", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
